// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first serial magnitude comparator over per-bit lt/eq/gt beats
module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic in_valid,
   output logic in_ready,
   input  logic bit_lt,
   input  logic bit_eq,
   input  logic bit_gt,
   output logic res_valid,
   input  logic res_ready,
   output logic less_than,
   output logic equal_to,
   output logic greater_than,
   output logic busy,
   output logic flag_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
   typedef enum logic [1:0] {DEC_UND, DEC_LT, DEC_GT} dec_t;

   state_t         state;
   dec_t           decision;
   dec_t           decision_nxt;
   logic [CW-1:0]  count;
   logic           beat_ok;
   logic           beat_fire;

   assign beat_ok   = ({bit_lt, bit_eq, bit_gt} == 3'b100) ||
                      ({bit_lt, bit_eq, bit_gt} == 3'b010) ||
                      ({bit_lt, bit_eq, bit_gt} == 3'b001);
   assign beat_fire = (state == S_ACCUM) && in_valid && in_ready;

   // The first non-equal legal beat (MSB first) decides; illegal beats count as equal.
   always_comb begin
      decision_nxt = decision;
      if (decision == DEC_UND && beat_ok) begin
         if (bit_gt)
            decision_nxt = DEC_GT;
         else if (bit_lt)
            decision_nxt = DEC_LT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         decision     <= DEC_UND;
         count        <= '0;
         in_ready     <= 1'b0;
         res_valid    <= 1'b0;
         less_than    <= 1'b0;
         equal_to     <= 1'b0;
         greater_than <= 1'b0;
         busy         <= 1'b0;
         flag_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_ACCUM;
                  count    <= CW'(WIDTH);
                  decision <= DEC_UND;
                  flag_err <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (beat_fire) begin
                  decision <= decision_nxt;
                  if (!beat_ok)
                     flag_err <= 1'b1;
                  if (count != '0)
                     count <= count - CW'(1);
                  if (count == CW'(1)) begin
                     state        <= S_DONE;
                     in_ready     <= 1'b0;
                     busy         <= 1'b0;
                     res_valid    <= 1'b1;
                     less_than    <= (decision_nxt == DEC_LT);
                     greater_than <= (decision_nxt == DEC_GT);
                     equal_to     <= (decision_nxt == DEC_UND);
                  end
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid    <= 1'b0;
                  less_than    <= 1'b0;
                  equal_to     <= 1'b0;
                  greater_than <= 1'b0;
                  // A start coinciding with the result handshake skips IDLE entirely.
                  if (start) begin
                     state    <= S_ACCUM;
                     count    <= CW'(WIDTH);
                     decision <= DEC_UND;
                     flag_err <= 1'b0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, in_valid = 1'b0, bit_lt = 1'b0, bit_eq = 1'b0, bit_gt = 1'b0, res_ready = 1'b0;
   logic in_ready, res_valid, less_than, equal_to, greater_than, busy, flag_err;
   logic start1 = 1'b0, in_valid1 = 1'b0, bit_lt1 = 1'b0, bit_eq1 = 1'b0, bit_gt1 = 1'b0, res_ready1 = 1'b0;
   logic in_ready1, res_valid1, less_than1, equal_to1, greater_than1, busy1, flag_err1;
   int total = 0;
   int bad = 0;

   wire [6:0] outs = {in_ready, res_valid, less_than, equal_to, greater_than, busy, flag_err};
   wire [2:0] res  = {less_than, equal_to, greater_than};

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .bit_lt(bit_lt), .bit_eq(bit_eq), .bit_gt(bit_gt), .res_valid(res_valid), .res_ready(res_ready),
      .less_than(less_than), .equal_to(equal_to), .greater_than(greater_than), .busy(busy), .flag_err(flag_err)
   );

   serial_magnitude_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
      .bit_lt(bit_lt1), .bit_eq(bit_eq1), .bit_gt(bit_gt1), .res_valid(res_valid1), .res_ready(res_ready1),
      .less_than(less_than1), .equal_to(equal_to1), .greater_than(greater_than1), .busy(busy1), .flag_err(flag_err1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_beat(input logic lt, input logic eq, input logic gt);
      bit_lt = lt; bit_eq = eq; bit_gt = gt; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; bit_lt = 1'b0; bit_eq = 1'b0; bit_gt = 1'b0;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (outs !== 7'b0) begin
         bad++; $display("FAIL reset_outputs got=%b want=%b", outs, 7'b0);
      end
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (outs !== 7'b0) begin
         bad++; $display("FAIL idle_after_release got=%b want=%b", outs, 7'b0);
      end
   endtask

   task automatic test_all_equal();
      pulse_start();
      total++;
      if ({busy, in_ready} !== 2'b11) begin
         bad++; $display("FAIL accum_entry busy_in_ready got=%b want=11", {busy, in_ready});
      end
      for (int i = 0; i < 8; i++) begin
         do_beat(1'b0, 1'b1, 1'b0);
         if (i < 7) begin
            total++;
            if (res_valid !== 1'b0) begin
               bad++; $display("FAIL early_res_valid beat=%0d got=%b want=0", i, res_valid);
            end
         end
      end
      total++;
      if (outs !== 7'b0101000) begin
         bad++; $display("FAIL all_equal_result got=%b want=%b", outs, 7'b0101000);
      end
      handshake();
      total++;
      if (outs !== 7'b0) begin
         bad++; $display("FAIL all_equal_idle got=%b want=%b", outs, 7'b0);
      end
   endtask

   task automatic test_msb_decides();
      pulse_start();
      do_beat(1'b0, 1'b0, 1'b1);
      for (int i = 1; i < 8; i++) do_beat(1'b1, 1'b0, 1'b0);
      total++;
      if ({res_valid, res, flag_err} !== 5'b10010) begin
         bad++; $display("FAIL msb_gt got=%b want=%b", {res_valid, res, flag_err}, 5'b10010);
      end
      handshake();
   endtask

   task automatic test_stall();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) do_beat(1'b1, 1'b0, 1'b0);
         else        do_beat(1'b0, 1'b1, 1'b0);
         if (i < 7) begin
            tick();
            total++;
            if ({busy, res_valid} !== 2'b10) begin
               bad++; $display("FAIL gap_hold beat=%0d got=%b want=10", i, {busy, res_valid});
            end
         end
      end
      for (int c = 0; c < 5; c++) begin
         total++;
         if ({res_valid, res} !== 4'b1100) begin
            bad++; $display("FAIL stall_stable cycle=%0d got=%b want=1100", c, {res_valid, res});
         end
         tick();
      end
      handshake();
      total++;
      if ({res_valid, res} !== 4'b0000) begin
         bad++; $display("FAIL stall_release got=%b want=0000", {res_valid, res});
      end
   endtask

   task automatic test_illegal_flags();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         if (i == 2) do_beat(1'b1, 1'b0, 1'b1);
         else        do_beat(1'b0, 1'b1, 1'b0);
      end
      total++;
      if ({res_valid, res, flag_err} !== 5'b10101) begin
         bad++; $display("FAIL illegal_result got=%b want=%b", {res_valid, res, flag_err}, 5'b10101);
      end
      handshake();
      total++;
      if ({res_valid, flag_err} !== 2'b01) begin
         bad++; $display("FAIL flag_err_sticky got=%b want=01", {res_valid, flag_err});
      end
      pulse_start();
      total++;
      if ({busy, flag_err} !== 2'b10) begin
         bad++; $display("FAIL flag_err_clear got=%b want=10", {busy, flag_err});
      end
      for (int i = 0; i < 8; i++) do_beat(1'b0, 1'b1, 1'b0);
      handshake();
   endtask

   task automatic test_reset_mid();
      pulse_start();
      for (int i = 0; i < 4; i++) do_beat(1'b0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== 7'b0) begin
         bad++; $display("FAIL async_reset got=%b want=%b", outs, 7'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      total++;
      if (outs !== 7'b0) begin
         bad++; $display("FAIL reset_discard got=%b want=%b", outs, 7'b0);
      end
      pulse_start();
      for (int i = 0; i < 8; i++) do_beat(1'b0, 1'b1, 1'b0);
      total++;
      if ({res_valid, res} !== 4'b1010) begin
         bad++; $display("FAIL post_reset_result got=%b want=1010", {res_valid, res});
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      pulse_start();
      do_beat(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 8; i++) do_beat(1'b0, 1'b1, 1'b0);
      total++;
      if ({res_valid, res} !== 4'b1100) begin
         bad++; $display("FAIL b2b_first got=%b want=1100", {res_valid, res});
      end
      res_ready = 1'b1;
      start = 1'b1;
      tick();
      res_ready = 1'b0;
      start = 1'b0;
      total++;
      if ({busy, in_ready, res_valid} !== 3'b110) begin
         bad++; $display("FAIL b2b_no_idle got=%b want=110", {busy, in_ready, res_valid});
      end
      do_beat(1'b0, 1'b0, 1'b1);
      for (int i = 1; i < 8; i++) do_beat(1'b0, 1'b1, 1'b0);
      total++;
      if ({res_valid, res} !== 4'b1001) begin
         bad++; $display("FAIL b2b_second got=%b want=1001", {res_valid, res});
      end
      handshake();
   endtask

   task automatic test_width_one();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      bit_lt1 = 1'b1; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0; bit_lt1 = 1'b0;
      total++;
      if ({res_valid1, less_than1, equal_to1, greater_than1, busy1} !== 5'b11000) begin
         bad++; $display("FAIL width1_result got=%b want=11000",
                         {res_valid1, less_than1, equal_to1, greater_than1, busy1});
      end
      res_ready1 = 1'b1;
      tick();
      res_ready1 = 1'b0;
      total++;
      if ({res_valid1, in_ready1, flag_err1} !== 3'b000) begin
         bad++; $display("FAIL width1_idle got=%b want=000", {res_valid1, in_ready1, flag_err1});
      end
   endtask

   initial begin
      test_reset();
      test_all_equal();
      test_msb_decides();
      test_stall();
      test_illegal_flags();
      test_reset_mid();
      test_back_to_back();
      test_width_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
